// File: rtl/indirect_branch_update_queue_pkg.sv
// Shared types and helpers for the indirect-branch update queue.
package indirect_branch_update_queue_pkg;

    localparam int unsigned SQN_W = 6;
    localparam int unsigned DST_W = 31;

    // Update lane handed to the indirect branch predictor.
    typedef struct packed {
        logic             valid;
        logic [DST_W-1:0] dst;
    } IndirBranchInfo;

    // One queue slot: a resolved target waiting for its branch to commit.
    typedef struct packed {
        logic             valid;
        logic [DST_W-1:0] dst;
        logic [SQN_W-1:0] sqn;
    } IBQEntry;

    // True when a is older than b; the modular difference keeps wrap-around safe.
    function automatic logic sqn_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return diff[SQN_W-1];
    endfunction

endpackage

// File: rtl/indirect_branch_update_queue.sv
// Holds resolved indirect-branch targets until their branch commits, drops
// flushed entries, and releases committed ones in order to the predictor.
module indirect_branch_update_queue
    import indirect_branch_update_queue_pkg::*;
#(
    parameter int unsigned NUM_IN      = 2,
    parameter int unsigned NUM_UPDATES = 2,
    parameter int unsigned DEPTH       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IN_clearICache,
    input  logic [NUM_IN-1:0] IN_brValid,
    input  logic [DST_W-1:0] IN_brDst [NUM_IN],
    input  logic [SQN_W-1:0] IN_brSqN [NUM_IN],
    input  logic [SQN_W-1:0] IN_comSqN,
    input  logic             IN_flushValid,
    input  logic [SQN_W-1:0] IN_flushSqN,
    output IndirBranchInfo   OUT_ibUpdates [NUM_UPDATES],
    output logic             OUT_overflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    IBQEntry        entries_q [DEPTH];
    IBQEntry        entries_d [DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    IndirBranchInfo upd_q [NUM_UPDATES];
    IndirBranchInfo upd_d [NUM_UPDATES];
    logic           ovf_q, ovf_d;

    int unsigned      cnt;
    int unsigned      n_pop;
    int unsigned      n_enq;
    int unsigned      lane;
    int unsigned      free_slots;
    logic             scan_ok;
    logic [IDX_W-1:0] slot;

    // Flush squash, in-order release scan, and port-ordered enqueue compaction.
    always_comb begin
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ovf_d      = 1'b0;
        cnt        = 32'(count_q);
        n_pop      = 0;
        n_enq      = 0;
        lane       = 0;
        free_slots = 0;
        scan_ok    = 1'b1;
        slot       = '0;
        for (int unsigned k = 0; k < NUM_UPDATES; k++) begin
            upd_d[k] = '0;
        end

        // Squash stored entries younger than the flush point; slots stay allocated.
        if (IN_flushValid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (sqn_older(IN_flushSqN, entries_q[i].sqn)) begin
                    entries_d[i].valid = 1'b0;
                end
            end
        end

        // Pop from head while slots are invalid or committed.
        for (int unsigned j = 0; j < NUM_UPDATES; j++) begin
            slot = head_q + IDX_W'(j);
            if (scan_ok && (j < cnt)) begin
                if (!entries_d[slot].valid || sqn_older(entries_d[slot].sqn, IN_comSqN)) begin
                    if (entries_d[slot].valid) begin
                        for (int unsigned k = 0; k < NUM_UPDATES; k++) begin
                            if (k == lane) begin
                                upd_d[k] = '{valid: 1'b1, dst: entries_d[slot].dst};
                            end
                        end
                        lane = lane + 1;
                    end
                    n_pop = n_pop + 1;
                end else begin
                    scan_ok = 1'b0;
                end
            end else begin
                scan_ok = 1'b0;
            end
        end

        // Enqueue surviving inputs into free space, lowest port first.
        free_slots = DEPTH - cnt + n_pop;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (IN_brValid[i] && !(IN_flushValid && sqn_older(IN_flushSqN, IN_brSqN[i]))) begin
                if (n_enq < free_slots) begin
                    slot = tail_q + IDX_W'(n_enq);
                    entries_d[slot] = '{valid: 1'b1, dst: IN_brDst[i], sqn: IN_brSqN[i]};
                    n_enq = n_enq + 1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end

        head_d  = head_q + IDX_W'(n_pop);
        tail_d  = tail_q + IDX_W'(n_enq);
        count_d = CNT_W'(cnt - n_pop + n_enq);

        // Instruction-cache clear wins over everything else this cycle.
        if (IN_clearICache) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            for (int unsigned k = 0; k < NUM_UPDATES; k++) begin
                upd_d[k] = '0;
            end
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // Queue storage, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            for (int unsigned k = 0; k < NUM_UPDATES; k++) begin
                upd_q[k] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            entries_q <= entries_d;
            upd_q     <= upd_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign OUT_ibUpdates = upd_q;
    assign OUT_overflow  = ovf_q;

endmodule

// File: tb/tb_indirect_branch_update_queue.sv
// Bench for the indirect-branch update queue: queue-level reference model,
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_indirect_branch_update_queue;
    import indirect_branch_update_queue_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           clear;
    logic [1:0]     br_valid;
    logic [30:0]    br_dst [2];
    logic [5:0]     br_sqn [2];
    logic [5:0]     com_sqn;
    logic           flush_valid;
    logic [5:0]     flush_sqn;
    IndirBranchInfo upd [2];
    logic           ovf;

    int errors = 0;
    int checks = 0;

    indirect_branch_update_queue #(.NUM_IN(2), .NUM_UPDATES(2), .DEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .IN_clearICache(clear),
        .IN_brValid    (br_valid),
        .IN_brDst      (br_dst),
        .IN_brSqN      (br_sqn),
        .IN_comSqN     (com_sqn),
        .IN_flushValid (flush_valid),
        .IN_flushSqN   (flush_sqn),
        .OUT_ibUpdates (upd),
        .OUT_overflow  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of pending branches.
    typedef struct {
        bit        valid;
        bit [30:0] dst;
        bit [5:0]  sqn;
    } ment_t;

    ment_t          mq[$];
    IndirBranchInfo exp_upd [2];
    bit             exp_ovf;

    function automatic bit older(input bit [5:0] a, input bit [5:0] b);
        bit signed [5:0] d;
        d = a - b;
        return d < 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        int unsigned lane;
        exp_upd[0] = '0;
        exp_upd[1] = '0;
        exp_ovf    = 1'b0;
        if (!rst_n || clear) begin
            mq.delete();
            return;
        end
        if (flush_valid) begin
            foreach (mq[i]) if (older(flush_sqn, mq[i].sqn)) mq[i].valid = 1'b0;
        end
        lane = 0;
        for (int j = 0; j < 2; j++) begin
            if (mq.size() == 0) break;
            if (mq[0].valid && !older(mq[0].sqn, com_sqn)) break;
            if (mq[0].valid) begin
                exp_upd[lane] = {1'b1, mq[0].dst};
                lane++;
            end
            void'(mq.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
            if (br_valid[i] && !(flush_valid && older(flush_sqn, br_sqn[i]))) begin
                if (mq.size() < 8) mq.push_back('{1'b1, br_dst[i], br_sqn[i]});
                else exp_ovf = 1'b1;
            end
        end
    endfunction

    // Advance the model on each edge and compare outputs just after it.
    always @(posedge clk) begin
        model_step();
        #1;
        check("lane0", 32'(upd[0]), 32'(exp_upd[0]));
        check("lane1", 32'(upd[1]), 32'(exp_upd[1]));
        check("overflow", 32'(ovf), 32'(exp_ovf));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        br_valid    = 2'b00;
        flush_valid = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic drive(input int p, input logic [5:0] s, input logic [30:0] d);
        br_valid[p] = 1'b1;
        br_sqn[p]   = s;
        br_dst[p]   = d;
    endtask

    int nvalid;

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        br_valid    = 2'b00;
        br_dst[0]   = '0;
        br_dst[1]   = '0;
        br_sqn[0]   = '0;
        br_sqn[1]   = '0;
        com_sqn     = '0;
        flush_valid = 1'b0;
        flush_sqn   = '0;
        repeat (3) tick();
        check("rst_lane0", 32'(upd[0]), 32'h0);
        check("rst_lane1", 32'(upd[1]), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        tick();

        // Release only once the branch commits.
        com_sqn = 6'd5;
        drive(0, 6'd5, 31'h100);
        tick();
        idle();
        repeat (3) begin
            tick();
            check("t2_hold", 32'(upd[0].valid), 32'h0);
        end
        com_sqn = 6'd6;
        tick();
        check("t2_release", 32'(upd[0]), {1'b1, 31'h100});
        tick();
        check("t2_once", 32'(upd[0].valid), 32'h0);

        // Flush squashes the younger entry and a same-cycle input.
        com_sqn = 6'd3;
        drive(0, 6'd3, 31'h0AAA);
        drive(1, 6'd4, 31'h0BBB);
        tick();
        idle();
        drive(0, 6'd7, 31'h0CCC);
        tick();
        idle();
        flush_valid = 1'b1;
        flush_sqn   = 6'd4;
        drive(0, 6'd9, 31'h0DDD);
        tick();
        idle();
        com_sqn = 6'd10;
        tick();
        check("t3_A", 32'(upd[0]), {1'b1, 31'h0AAA});
        check("t3_B", 32'(upd[1]), {1'b1, 31'h0BBB});
        repeat (2) begin
            tick();
            check("t3_noC0", 32'(upd[0].valid), 32'h0);
            check("t3_noC1", 32'(upd[1].valid), 32'h0);
        end

        // Fill, overflow, then same-cycle pop and push.
        com_sqn = 6'd20;
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'(30 + 2 * i), 31'(32'h1000 + 30 + 2 * i));
            drive(1, 6'(31 + 2 * i), 31'(32'h1000 + 31 + 2 * i));
            tick();
        end
        check("t4_no_ovf_yet", 32'(ovf), 32'h0);
        drive(0, 6'd40, 31'h1040);
        drive(1, 6'd41, 31'h1041);
        tick();
        check("t4_ovf", 32'(ovf), 32'h1);
        idle();
        com_sqn = 6'd32;
        drive(0, 6'd42, 31'h1042);
        drive(1, 6'd43, 31'h1043);
        tick();
        check("t4_pulse", 32'(ovf), 32'h0);
        check("t4_pop30", 32'(upd[0]), {1'b1, 31'h101E});
        check("t4_pop31", 32'(upd[1]), {1'b1, 31'h101F});
        idle();
        com_sqn = 6'd44;
        nvalid = 0;
        repeat (6) begin
            tick();
            nvalid += int'(upd[0].valid) + int'(upd[1].valid);
            if (upd[1].valid) check("t4_last_is_young", 32'(upd[1].dst >= upd[0].dst), 32'h1);
        end
        check("t4_drained", 32'(nvalid), 32'd8);

        // Sequence-number wrap.
        com_sqn = 6'h3E;
        drive(0, 6'h3E, 31'h2E);
        drive(1, 6'h3F, 31'h2F);
        tick();
        idle();
        drive(0, 6'h00, 31'h20);
        tick();
        idle();
        com_sqn = 6'h01;
        tick();
        check("t5_3E", 32'(upd[0]), {1'b1, 31'h2E});
        check("t5_3F", 32'(upd[1]), {1'b1, 31'h2F});
        tick();
        check("t5_00", 32'(upd[0]), {1'b1, 31'h20});
        check("t5_lane1", 32'(upd[1].valid), 32'h0);

        // Uncommitted head blocks; clear empties the queue.
        com_sqn = 6'd3;
        drive(0, 6'd8, 31'h888);
        drive(1, 6'd2, 31'h222);
        tick();
        idle();
        repeat (3) begin
            tick();
            check("t6_block", 32'({upd[1].valid, upd[0].valid}), 32'h0);
        end
        clear = 1'b1;
        tick();
        clear   = 1'b0;
        com_sqn = 6'd9;
        repeat (2) begin
            tick();
            check("t6_cleared", 32'({upd[1].valid, upd[0].valid}), 32'h0);
        end

        // Async reset mid-cycle clears a live output immediately.
        com_sqn = 6'h10;
        drive(0, 6'd5, 31'h555);
        tick();
        idle();
        tick();
        check("rst_pre", 32'(upd[0]), {1'b1, 31'h555});
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(upd[0].valid), 32'h0);
        tick();
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            clear       = ($urandom_range(0, 63) == 0);
            flush_valid = ($urandom_range(0, 15) == 0);
            flush_sqn   = 6'(com_sqn + 6'($urandom_range(0, 8)));
            for (int p = 0; p < 2; p++) begin
                br_valid[p] = ($urandom_range(0, 2) != 0);
                br_sqn[p]   = 6'(com_sqn + 6'($urandom_range(0, 12)));
                br_dst[p]   = 31'($urandom);
            end
            if ($urandom_range(0, 3) == 0) com_sqn = 6'(com_sqn + 6'($urandom_range(0, 3)));
        end
        tick();
        idle();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
